// File: rtl/timer_set_ctrl_pkg.sv
// Shared types and constants for the countdown-timer set/run controller.
package timer_set_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EDIT_HOUR = 3'd1,
    S_EDIT_MIN  = 3'd2,
    S_EDIT_SEC  = 3'd3,
    S_RUN       = 3'd4,
    S_PAUSE     = 3'd5,
    S_RINGING   = 3'd6
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
  localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;

  function automatic logic [1:0] field_of(input state_e s);
    case (s)
      S_EDIT_HOUR: field_of = FIELD_HOUR;
      S_EDIT_MIN:  field_of = FIELD_MIN;
      S_EDIT_SEC:  field_of = FIELD_SEC;
      default:     field_of = FIELD_NONE;
    endcase
  endfunction

  // Mode button walks the edit fields and falls back to IDLE after seconds.
  function automatic state_e mode_next(input state_e s);
    case (s)
      S_IDLE:      mode_next = S_EDIT_HOUR;
      S_EDIT_HOUR: mode_next = S_EDIT_MIN;
      S_EDIT_MIN:  mode_next = S_EDIT_SEC;
      default:     mode_next = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Packed-BCD increment/decrement by one with wrap between 00 and max.
module bcd_step (
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       dir,
  output logic [7:0] next
);

  always_comb begin
    next = value;
    if (dir) begin
      if (value == max)               next = 8'h00;
      else if (value[3:0] == 4'h9)    next = {value[7:4] + 4'h1, 4'h0};
      else                            next = {value[7:4], value[3:0] + 4'h1};
    end else begin
      if (value == 8'h00)             next = max;
      else if (value[3:0] == 4'h0)    next = {value[7:4] - 4'h1, 4'h9};
      else                            next = {value[7:4], value[3:0] - 4'h1};
    end
  end

endmodule

// File: rtl/timer_set_ctrl.sv
// Button-driven set/start/pause/ring controller for a BCD countdown timer.
// Define TIMER_SET_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
module timer_set_ctrl
  import timer_set_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       ring,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       load,
  output logic       clock_en,
  output logic [1:0] edit_field,
  output logic       running
);

  localparam int B_DOWN  = 0;
  localparam int B_UP    = 1;
  localparam int B_MODE  = 2;
  localparam int B_START = 3;

  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q, press_q, press_d;

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic       load_q, load_d, clock_en_q, clock_en_d, running_q, running_d;
  logic [1:0] edit_field_q, edit_field_d;

  logic       in_edit, rep_up, rep_dn, up_evt, dn_evt, step_en;
  logic       set_nonzero, any_press;
  logic [7:0] step_cur, step_max, step_next;

  assign btn_raw = {btn_start, btn_mode, btn_up, btn_down};
  assign press_d = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= press_d;
    end
  end

  assign in_edit = (state_q == S_EDIT_HOUR) || (state_q == S_EDIT_MIN) ||
                   (state_q == S_EDIT_SEC);

`ifdef TIMER_SET_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
  logic             rep_first_q, rep_first_d, rep_held, rep_fire;

  // Counter holds cycles since the last step; first gap is the long delay.
  assign rep_held  = in_edit && (sync2_q[B_UP] ^ sync2_q[B_DOWN]);
  assign rep_limit = rep_first_q ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (!rep_held) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (press_q[B_UP] || press_q[B_DOWN]) begin
      rep_cnt_d   = CNT_W'(1);
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == rep_limit) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = CNT_W'(1);
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d   = rep_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign rep_up = rep_fire && sync2_q[B_UP];
  assign rep_dn = rep_fire && sync2_q[B_DOWN];
`else
  logic unused_params;
  assign unused_params = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign up_evt      = press_q[B_UP] | rep_up;
  assign dn_evt      = press_q[B_DOWN] | rep_dn;
  assign step_en     = up_evt ^ dn_evt;
  assign set_nonzero = |{hour_q, minute_q, second_q};
  assign any_press   = |press_q;

  always_comb begin
    step_cur = second_q;
    step_max = MINSEC_MAX_BCD;
    case (state_q)
      S_EDIT_HOUR: begin
        step_cur = hour_q;
        step_max = HOUR_MAX_BCD;
      end
      S_EDIT_MIN:  step_cur = minute_q;
      default:     step_cur = second_q;
    endcase
  end

  bcd_step u_bcd_step (
    .value (step_cur),
    .max   (step_max),
    .dir   (up_evt),
    .next  (step_next)
  );

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    load_d   = 1'b0;
    case (state_q)
      S_IDLE, S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC: begin
        if (press_q[B_START]) begin
          if (set_nonzero) begin
            state_d = S_RUN;
            load_d  = 1'b1;
          end
        end else if (press_q[B_MODE]) begin
          state_d = mode_next(state_q);
        end else if (in_edit && step_en) begin
          case (state_q)
            S_EDIT_HOUR: hour_d   = step_next;
            S_EDIT_MIN:  minute_d = step_next;
            default:     second_d = step_next;
          endcase
        end
      end
      // ring is checked before start so time-up always wins
      S_RUN: begin
        if (ring)                  state_d = S_RINGING;
        else if (press_q[B_START]) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (ring)                  state_d = S_RINGING;
        else if (press_q[B_START]) state_d = S_RUN;
        else if (press_q[B_MODE])  state_d = S_IDLE;
      end
      S_RINGING: begin
        if (any_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Enable waits out the load cycle so downstream counts from the loaded value.
    clock_en_d   = (state_d == S_RUN) && !load_d;
    running_d    = (state_d == S_RUN);
    edit_field_d = field_of(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hour_q       <= 8'h00;
      minute_q     <= 8'h00;
      second_q     <= 8'h00;
      load_q       <= 1'b0;
      clock_en_q   <= 1'b0;
      running_q    <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      minute_q     <= minute_d;
      second_q     <= second_d;
      load_q       <= load_d;
      clock_en_q   <= clock_en_d;
      running_q    <= running_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign hour_bcd_out   = hour_q;
  assign minute_bcd_out = minute_q;
  assign second_bcd_out = second_q;
  assign load           = load_q;
  assign clock_en       = clock_en_q;
  assign running        = running_q;
  assign edit_field     = edit_field_q;

endmodule
